// File: rtl/switch_input.sv
// switch_input: per-bit synchronizer and debouncer for raw switch pins, with
// one-cycle rise/fall pulses and sticky rise flags that can be cleared.
module switch_input #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] pin_switch,
  input  logic             event_clear,
  output logic [WIDTH-1:0] switch_value,
  output logic [WIDTH-1:0] switch_rise,
  output logic [WIDTH-1:0] switch_fall,
  output logic [WIDTH-1:0] event_flags,
  output logic             event_pending
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_flags;
  logic             r_pending;

  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_accept;
  logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0] w_value_nxt;
  logic [WIDTH-1:0] w_rise_nxt;
  logic [WIDTH-1:0] w_fall_nxt;
  logic [WIDTH-1:0] w_flags_nxt;
  logic             w_pending_nxt;

  // Two-flop synchronizer for the asynchronous switch pins
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= pin_switch;
      r_s2 <= r_s1;
    end
  end

  // Per-bit stability counting, acceptance and sticky-flag next state
  always_comb begin
    w_diff   = '0;
    w_accept = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_cnt_nxt[i] = '0;
    end
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_diff[i]   = r_s2[i] ^ r_value[i];
      w_accept[i] = w_diff[i] && (r_cnt[i] == CNT_LAST);
      // Counter restarts on a match and on acceptance, so it never passes CNT_LAST
      if (w_diff[i] && !w_accept[i]) begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
      end
    end
    w_value_nxt   = r_value ^ w_accept;
    w_rise_nxt    = w_accept & r_s2;
    w_fall_nxt    = w_accept & ~r_s2;
    // A new rise wins over a coincident clear
    w_flags_nxt   = (event_clear ? '0 : r_flags) | w_rise_nxt;
    w_pending_nxt = |w_flags_nxt;
  end

  // Debounce state and registered outputs
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_cnt[i] <= '0;
      end
      r_value   <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_flags   <= '0;
      r_pending <= 1'b0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_value   <= w_value_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_flags   <= w_flags_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  assign switch_value  = r_value;
  assign switch_rise   = r_rise;
  assign switch_fall   = r_fall;
  assign event_flags   = r_flags;
  assign event_pending = r_pending;

endmodule

// File: tb/tb_switch_input.sv
// tb_switch_input: directed vector bench for switch_input (WIDTH=4, STABLE_CYCLES=4).
module tb_switch_input;

  localparam int unsigned WIDTH = 4;

  typedef struct {
    logic [3:0] pin;
    logic       clr;
    logic [3:0] val;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] flags;
    logic       pend;
  } vec_t;

  logic             clock;
  logic             n_reset;
  logic [WIDTH-1:0] pin_switch;
  logic             event_clear;
  logic [WIDTH-1:0] switch_value;
  logic [WIDTH-1:0] switch_rise;
  logic [WIDTH-1:0] switch_fall;
  logic [WIDTH-1:0] event_flags;
  logic             event_pending;

  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  switch_input #(
    .WIDTH(4),
    .STABLE_CYCLES(4)
  ) dut (
    .clock        (clock),
    .n_reset      (n_reset),
    .pin_switch   (pin_switch),
    .event_clear  (event_clear),
    .switch_value (switch_value),
    .switch_rise  (switch_rise),
    .switch_fall  (switch_fall),
    .event_flags  (event_flags),
    .event_pending(event_pending)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step=%0d actual=%b expected=%b", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic [3:0] val, input logic [3:0] rise,
                           input logic [3:0] fall, input logic [3:0] flags, input logic pend);
    check({tag, ".value"}, idx, switch_value, val);
    check({tag, ".rise"},  idx, switch_rise,  rise);
    check({tag, ".fall"},  idx, switch_fall,  fall);
    check({tag, ".flags"}, idx, event_flags,  flags);
    check({tag, ".pending"}, idx, {3'b000, event_pending}, {3'b000, pend});
  endtask

  // Append n identical per-edge rows
  task automatic add_run(input int n, input logic [3:0] pin, input logic clr, input logic [3:0] val,
                         input logic [3:0] rise, input logic [3:0] fall, input logic [3:0] flags, input logic pend);
    vec_t v;
    v.pin = pin; v.clr = clr; v.val = val; v.rise = rise;
    v.fall = fall; v.flags = flags; v.pend = pend;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  // Drive inputs, take one rising edge, then sample just after it
  task automatic step(input logic [3:0] pin, input logic clr);
    pin_switch  = pin;
    event_clear = clr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    n_reset     = 1'b0;
    pin_switch  = 4'd6;
    event_clear = 1'b0;

    // Rows: inputs applied before the edge, outputs expected after it
    add_run(5,  4'd6,  1'b0, 4'd0,  4'd0, 4'd0, 4'd0,  1'b0); // power-up, not yet accepted
    add_run(1,  4'd6,  1'b0, 4'd6,  4'd6, 4'd0, 4'd6,  1'b1); // edge 6 accept
    add_run(1,  4'd6,  1'b0, 4'd6,  4'd0, 4'd0, 4'd6,  1'b1); // pulse is one cycle
    add_run(3,  4'd7,  1'b0, 4'd6,  4'd0, 4'd0, 4'd6,  1'b1); // bit0 glitch, 3 cycles
    add_run(4,  4'd6,  1'b0, 4'd6,  4'd0, 4'd0, 4'd6,  1'b1); // glitch rejected
    add_run(5,  4'd2,  1'b0, 4'd6,  4'd0, 4'd0, 4'd6,  1'b1); // 6 -> 2 pending
    add_run(1,  4'd2,  1'b0, 4'd2,  4'd0, 4'd4, 4'd6,  1'b1); // fall on bit2, flags kept
    add_run(1,  4'd2,  1'b0, 4'd2,  4'd0, 4'd0, 4'd6,  1'b1);
    add_run(2,  4'd10, 1'b0, 4'd2,  4'd0, 4'd0, 4'd6,  1'b1); // bit3 bounce 1
    add_run(2,  4'd2,  1'b0, 4'd2,  4'd0, 4'd0, 4'd6,  1'b1); // bit3 bounce 0
    add_run(5,  4'd10, 1'b0, 4'd2,  4'd0, 4'd0, 4'd6,  1'b1); // final 1 held
    add_run(1,  4'd10, 1'b0, 4'd10, 4'd8, 4'd0, 4'd14, 1'b1); // 6th edge after final edge
    add_run(1,  4'd10, 1'b0, 4'd10, 4'd0, 4'd0, 4'd14, 1'b1);
    add_run(3,  4'd11, 1'b0, 4'd10, 4'd0, 4'd0, 4'd14, 1'b1); // bit0 rising
    add_run(2,  4'd11, 1'b1, 4'd10, 4'd0, 4'd0, 4'd0,  1'b0); // held clear
    add_run(1,  4'd11, 1'b1, 4'd11, 4'd1, 4'd0, 4'd1,  1'b1); // set wins over clear
    add_run(1,  4'd11, 1'b0, 4'd11, 4'd0, 4'd0, 4'd1,  1'b1);
    add_run(1,  4'd11, 1'b1, 4'd11, 4'd0, 4'd0, 4'd0,  1'b0); // single clear
    add_run(1,  4'd11, 1'b0, 4'd11, 4'd0, 4'd0, 4'd0,  1'b0);
    add_run(5,  4'd9,  1'b0, 4'd11, 4'd0, 4'd0, 4'd0,  1'b0); // bit1 falling
    add_run(1,  4'd9,  1'b0, 4'd9,  4'd0, 4'd2, 4'd0,  1'b0);
    add_run(1,  4'd9,  1'b0, 4'd9,  4'd0, 4'd0, 4'd0,  1'b0);

    // Outputs held at zero by reset across a clock edge
    #7;
    check_all("in_reset", 0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    #3;
    n_reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].pin, vecs[i].clr);
      check_all("vec", i + 1, vecs[i].val, vecs[i].rise, vecs[i].fall, vecs[i].flags, vecs[i].pend);
    end

    // Reset mid-count: bit1 pending rise reaches count 2, then reset
    for (int e = 1; e <= 4; e++) begin
      step(4'd11, 1'b0);
      check_all("pre_reset", e, 4'd9, 4'd0, 4'd0, 4'd0, 1'b0);
    end
    n_reset = 1'b0;
    #2;
    check_all("mid_reset", 0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    #3;
    n_reset = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step(4'd11, 1'b0);
      check_all("post_reset", e, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    end
    step(4'd11, 1'b0);
    check_all("post_reset", 6, 4'd11, 4'd11, 4'd0, 4'd11, 1'b1);
    step(4'd11, 1'b0);
    check_all("post_reset", 7, 4'd11, 4'd0, 4'd0, 4'd11, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
